// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one multicycle ALU between two requesters,
// screens out illegal or divide-by-zero ops and returns one tagged response per grant.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_POW = 3'b101;
  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  logic            rr_ptr;
  logic [CW-1:0]   cnt;

  logic            any_valid;
  logic            grant;
  logic [WIDTH-1:0] g_a;
  logic [WIDTH-1:0] g_b;
  logic [2:0]      g_sel;
  logic            g_err;

  // With both requesters valid the round-robin pointer decides; otherwise the lone one wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    g_a       = grant ? req1_a   : req0_a;
    g_b       = grant ? req1_b   : req0_b;
    g_sel     = grant ? req1_sel : req0_sel;
    g_err     = (g_sel > OP_POW) || (((g_sel == OP_DIV) || (g_sel == OP_MOD)) && (g_b == '0));
  end

  assign req0_ready = (state == IDLE) && !grant && req0_valid;
  assign req1_ready = (state == IDLE) &&  grant && req1_valid;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_a   <= g_a;
            alu_b   <= g_b;
            alu_sel <= g_sel;
            rsp_id  <= grant;
            rr_ptr  <= ~grant;
            if (g_err) begin
              rsp_err   <= 1'b1;
              rsp_y     <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              cnt   <= CW'(ALU_LAT);
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            rsp_y     <= alu_y;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle plus directed
// literal expectations; a second instance covers the ALU_LAT=3 timing.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam int LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_sel, req1_sel;
  logic [W-1:0] alu_a, alu_b, alu_y, rsp_y;
  logic [2:0]   alu_sel;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

  logic         t3_req0_valid, t3_req0_ready, t3_req1_valid, t3_req1_ready;
  logic [W-1:0] t3_req0_a, t3_req0_b, t3_req1_a, t3_req1_b;
  logic [2:0]   t3_req0_sel, t3_req1_sel;
  logic [W-1:0] t3_alu_a, t3_alu_b, t3_alu_y, t3_rsp_y;
  logic [2:0]   t3_alu_sel;
  logic         t3_rsp_valid, t3_rsp_ready, t3_rsp_id, t3_rsp_err, t3_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic logic [W-1:0] alu_fn(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r, base;
    case (s)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a * b;
      3'd3: r = (b == 0) ? '0 : a / b;
      3'd4: r = (b == 0) ? '0 : a % b;
      3'd5: begin
        r = 1;
        base = a;
        for (int i = 0; i < W; i++) begin
          if (b[i]) r = r * base;
          base = base * base;
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_y    = alu_fn(alu_sel, alu_a, alu_b);
  assign t3_alu_y = alu_fn(t3_alu_sel, t3_alu_a, t3_alu_b);

  alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .busy(busy)
  );

  alu_arbiter #(.WIDTH(W), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(t3_req0_valid), .req0_ready(t3_req0_ready), .req0_a(t3_req0_a), .req0_b(t3_req0_b), .req0_sel(t3_req0_sel),
    .req1_valid(t3_req1_valid), .req1_ready(t3_req1_ready), .req1_a(t3_req1_a), .req1_b(t3_req1_b), .req1_sel(t3_req1_sel),
    .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_sel(t3_alu_sel), .alu_y(t3_alu_y),
    .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready), .rsp_id(t3_rsp_id), .rsp_y(t3_rsp_y), .rsp_err(t3_rsp_err),
    .busy(t3_busy)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: one pending op, ready time computed from latency.
  bit           m_live = 0, m_pend = 0, m_id = 0, m_err = 0, m_rr = 0;
  bit           m_g, m_r0, m_r1, m_v;
  logic [W-1:0] m_y, m_la, m_lb, m_a, m_b;
  logic [2:0]   m_lsel, m_s;
  int           m_at = 0, m_c = 0;

  always @(negedge clk) begin
    m_c++;
    if (rst) begin
      m_live = 1; m_pend = 0; m_rr = 0; m_la = '0; m_lb = '0; m_lsel = '0;
    end else if (m_live) begin
      if (req0_valid && req1_valid) m_g = m_rr;
      else m_g = !req0_valid;
      m_r0 = !m_pend && req0_valid && !m_g;
      m_r1 = !m_pend && req1_valid && m_g;
      m_v  = m_pend && (m_c >= m_at);
      check("m_req0_ready", req0_ready, m_r0);
      check("m_req1_ready", req1_ready, m_r1);
      check("m_rsp_valid", rsp_valid, m_v);
      check("m_busy", busy, m_pend);
      check("m_alu_a", alu_a, m_la);
      check("m_alu_b", alu_b, m_lb);
      check("m_alu_sel", alu_sel, m_lsel);
      if (m_v) begin
        check("m_rsp_id", rsp_id, m_id);
        check("m_rsp_y", rsp_y, m_y);
        check("m_rsp_err", rsp_err, m_err);
      end
      if (m_v && rsp_ready) m_pend = 0;
      else if (m_r0 || m_r1) begin
        m_a = m_g ? req1_a : req0_a;
        m_b = m_g ? req1_b : req0_b;
        m_s = m_g ? req1_sel : req0_sel;
        m_la = m_a; m_lb = m_b; m_lsel = m_s;
        m_id  = m_g;
        m_err = (m_s > 3'd5) || ((m_s == 3'd3 || m_s == 3'd4) && m_b == 0);
        m_y   = m_err ? '0 : alu_fn(m_s, m_a, m_b);
        m_at  = m_c + (m_err ? 1 : LAT + 1);
        m_rr  = !m_g;
        m_pend = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int           hold_n = 0, last_stall = 0;
  int           hs_at[2];
  bit           q_id[$], q_err[$];
  logic [W-1:0] q_y[$];
  int           q_lat[$];

  task automatic clear_q();
    q_id.delete(); q_err.delete(); q_y.delete(); q_lat.delete();
  endtask

  // Drives the current requests until n responses are accepted; each valid drops after its handshake.
  task automatic run(input int n);
    int got = 0, c = 0, stall = 0, vfirst = 0;
    bit prev_v = 0, h0, h1;
    while (got < n && c < 60) begin
      rsp_ready = (stall >= hold_n);
      #1;
      if (rsp_valid && !prev_v) vfirst = cyc;
      prev_v = rsp_valid;
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (h0) hs_at[0] = cyc;
      if (h1) hs_at[1] = cyc;
      if (rsp_valid && !rsp_ready) stall++;
      if (rsp_valid && rsp_ready) begin
        q_id.push_back(rsp_id); q_y.push_back(rsp_y); q_err.push_back(rsp_err);
        q_lat.push_back(vfirst - hs_at[rsp_id]);
        last_stall = stall;
        stall = 0;
        got++;
      end
      tick();
      if (h0) req0_valid = 0;
      if (h1) req1_valid = 0;
      c++;
    end
    check("run_responses", got, n);
    rsp_ready = 1;
  endtask

  task automatic set0(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_sel = s; req0_a = a; req0_b = b; req0_valid = 1;
  endtask

  task automatic set1(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_sel = s; req1_a = a; req1_b = b; req1_valid = 1;
  endtask

  initial begin
    rst = 1; rsp_ready = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    t3_req0_valid = 0; t3_req0_a = 0; t3_req0_b = 0; t3_req0_sel = 0;
    t3_req1_valid = 0; t3_req1_a = 0; t3_req1_b = 0; t3_req1_sel = 0;
    t3_rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_rsp_y", rsp_y, 0);

    // Reset while in EXEC abandons the op.
    set0(3'd0, 32'd3, 32'd4);
    #1 check("t1_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    check("t1_busy_exec", busy, 1);
    rst = 1;
    tick();
    check("t1_rst_rsp_valid", rsp_valid, 0);
    check("t1_rst_busy", busy, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      check("t1_no_rsp", rsp_valid, 0);
      tick();
    end

    // Single ADD: alu loaded at T+1, response at T+2.
    set0(3'd0, 32'd10, 32'd2);
    #1 check("t2_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    check("t2_alu_sel", alu_sel, 3'b000);
    check("t2_alu_a", alu_a, 32'd10);
    check("t2_not_valid", rsp_valid, 0);
    tick();
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_y", rsp_y, 32'd12);
    check("t2_rsp_id", rsp_id, 0);
    check("t2_rsp_err", rsp_err, 0);
    tick();
    check("t2_rsp_drop", rsp_valid, 0);

    rst = 1;
    tick();
    rst = 0;

    // Both valid: rr pointer alternates, req0 first after reset.
    for (int r = 0; r < 2; r++) begin
      clear_q();
      set0(3'd1, 32'd10, 32'd2);
      set1(3'd2, 32'd10, 32'd2);
      run(2);
      if (q_id.size() == 2) begin
        check("t3_first_id", q_id[0], 0);
        check("t3_first_y", q_y[0], 32'd8);
        check("t3_second_id", q_id[1], 1);
        check("t3_second_y", q_y[1], 32'd20);
        check("t3_latency", q_lat[0], 2);
      end
    end

    // DIV by zero caught before issue, then a legal MOD.
    clear_q();
    set1(3'd3, 32'd10, 32'd0);
    run(1);
    set1(3'd4, 32'd10, 32'd3);
    run(1);
    if (q_id.size() == 2) begin
      check("t4_div0_err", q_err[0], 1);
      check("t4_div0_y", q_y[0], 0);
      check("t4_div0_lat", q_lat[0], 1);
      check("t4_div0_id", q_id[0], 1);
      check("t4_mod_y", q_y[1], 32'd1);
      check("t4_mod_err", q_err[1], 0);
    end

    // Unused opcode, then POW with consumer stalling 5 cycles.
    clear_q();
    set0(3'b111, 32'd10, 32'd2);
    run(1);
    hold_n = 5;
    set0(3'd5, 32'd10, 32'd2);
    run(1);
    hold_n = 0;
    if (q_id.size() == 2) begin
      check("t5_bad_err", q_err[0], 1);
      check("t5_bad_y", q_y[0], 0);
      check("t5_bad_lat", q_lat[0], 1);
      check("t5_pow_y", q_y[1], 32'd100);
      check("t5_pow_err", q_err[1], 0);
      check("t5_stall", last_stall, 5);
    end

    // ALU_LAT=3 instance: operands stable T+1..T+3, response at T+4.
    t3_req0_a = 32'd7; t3_req0_b = 32'd5; t3_req0_sel = 3'd0; t3_req0_valid = 1;
    #1 check("t6_ready0", t3_req0_ready, 1);
    tick();
    t3_req0_valid = 0;
    for (int k = 0; k < 3; k++) begin
      check("t6_alu_a", t3_alu_a, 32'd7);
      check("t6_alu_b", t3_alu_b, 32'd5);
      check("t6_alu_sel", t3_alu_sel, 3'd0);
      check("t6_not_valid", t3_rsp_valid, 0);
      check("t6_busy", t3_busy, 1);
      tick();
    end
    check("t6_rsp_valid", t3_rsp_valid, 1);
    check("t6_rsp_y", t3_rsp_y, 32'd12);
    check("t6_rsp_err", t3_rsp_err, 0);
    check("t6_rsp_id", t3_rsp_id, 0);
    tick();
    check("t6_rsp_drop", t3_rsp_valid, 0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
